// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-side bus: program memory read port, execute-stage handshake, status
//
// Purpose: bundles every non-clock signal of instr_fetch.
//   master : the fetch sequencer (drives memory enable/address, decoded instruction, status)
//   slave  : the surroundings (program memory, execute stage, run control)
// Signals:
//   start                 run control, sampled only when the sequencer is idle or done
//   mem_en, mem_addr      memory read request
//   mem_data              memory read data, one cycle after the request edge
//   instr_valid/ready     instruction handshake toward the execute stage
//   a_in,b_in,c_in,op_code decoded instruction fields
//   pc                    address of the instruction being fetched or presented
//   busy, done            status
interface instr_fetch_if #(
  parameter int ADDR_W  = 3,
  parameter int FRAME_W = 13
);
  logic               start;
  logic               mem_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [FRAME_W-1:0] mem_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [3:0]         a_in;
  logic [3:0]         b_in;
  logic               c_in;
  logic [3:0]         op_code;
  logic [ADDR_W-1:0]  pc;
  logic               busy;
  logic               done;

  modport master (
    input  start, mem_data, instr_ready,
    output mem_en, mem_addr, instr_valid, a_in, b_in, c_in, op_code, pc, busy, done
  );

  modport slave (
    output start, mem_data, instr_ready,
    input  mem_en, mem_addr, instr_valid, a_in, b_in, c_in, op_code, pc, busy, done
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch sequencer for the 4-bit ALU CPU
//
// Purpose: walks program memory from address 0, issues one read per instruction,
// captures the frame one cycle later, splits it into a_in/b_in/c_in/op_code and
// holds it under a valid/ready handshake until the execute stage accepts it.
// Per-instruction sequence: ISSUE -> CAPTURE -> HOLD (3 cycles with ready held high).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    instr_fetch_if.master (memory read port, instruction handshake, status)
// Build option:
//   FETCH_LOOP_EN  defined: after the last entry, pc wraps to 0 and fetching
//                  continues forever (DONE unreachable); undefined: stop in DONE.
module instr_fetch #(
  parameter int ADDR_W   = 3,
  parameter int FRAME_W  = 13,
  parameter int PROG_LEN = 6
) (
  input logic            clk,
  input logic            rst_n,
  instr_fetch_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  state_t             r_state;
  logic               r_mem_en;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_instr_valid;
  logic [3:0]         r_a_in;
  logic [3:0]         r_b_in;
  logic               r_c_in;
  logic [3:0]         r_op_code;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_busy;
  logic               r_done;

  logic [ADDR_W-1:0]  w_pc_next;

  assign w_pc_next = r_pc + ADDR_W'(1);

  // Every output is a register updated on state transitions, so nothing on the
  // bus depends combinationally on start, instr_ready or mem_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mem_en      <= 1'b0;
      r_mem_addr    <= '0;
      r_instr_valid <= 1'b0;
      r_a_in        <= '0;
      r_b_in        <= '0;
      r_c_in        <= 1'b0;
      r_op_code     <= '0;
      r_pc          <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_pc       <= '0;
            r_mem_en   <= 1'b1;
            r_mem_addr <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // The read request lives for exactly one cycle.
          r_mem_en <= 1'b0;
          r_state  <= S_CAPTURE;
        end

        S_CAPTURE: begin
          r_a_in        <= bus.mem_data[FRAME_W-1 -: 4];
          r_b_in        <= bus.mem_data[FRAME_W-5 -: 4];
          r_c_in        <= bus.mem_data[4];
          r_op_code     <= bus.mem_data[3:0];
          r_instr_valid <= 1'b1;
          r_state       <= S_HOLD;
        end

        S_HOLD: begin
          // No read is issued until the held instruction is accepted, so
          // backpressure can never overwrite or skip an entry.
          if (bus.instr_ready) begin
            r_instr_valid <= 1'b0;
            if (r_pc == LAST_PC) begin
`ifdef FETCH_LOOP_EN
              r_pc       <= '0;
              r_mem_en   <= 1'b1;
              r_mem_addr <= '0;
              r_state    <= S_ISSUE;
`else
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
`endif
            end else begin
              r_pc       <= w_pc_next;
              r_mem_en   <= 1'b1;
              r_mem_addr <= w_pc_next;
              r_state    <= S_ISSUE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en      = r_mem_en;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.a_in        = r_a_in;
  assign bus.b_in        = r_b_in;
  assign bus.c_in        = r_c_in;
  assign bus.op_code     = r_op_code;
  assign bus.pc          = r_pc;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch (PROG_LEN=6 and PROG_LEN=1 instances)
module tb_instr_fetch;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] op;
    logic [2:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(3), .FRAME_W(13)) bus  ();
  instr_fetch_if #(.ADDR_W(3), .FRAME_W(13)) bus1 ();

  instr_fetch #(.ADDR_W(3), .FRAME_W(13), .PROG_LEN(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  instr_fetch #(.ADDR_W(3), .FRAME_W(13), .PROG_LEN(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.master)
  );

  // Program: (a, b, c, op) per address; entries 6 and 7 must never be read.
  int prog_a  [8] = '{2, 2, 4, 8, 7,  1, 15, 15};
  int prog_b  [8] = '{8, 7, 3, 2, 10, 8, 15, 15};
  int prog_c  [8] = '{1, 0, 0, 1, 0,  0, 1,  1};
  int prog_op [8] = '{0, 1, 1, 2, 4,  7, 15, 15};

  logic [12:0] rom [8];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb_q [$];
  logic mon_en = 1'b0;
  logic chk_tput = 1'b0;
  int   prev_xfer = -1;
  int   last_xfer = -1;
  int   n_xfer = 0;
  int   mem_en1_cnt = 0;
  logic saw_done = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_prog(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      exp_t e;
      e.a  = 4'(prog_a[i % 6]);
      e.b  = 4'(prog_b[i % 6]);
      e.c  = 1'(prog_c[i % 6]);
      e.op = 4'(prog_op[i % 6]);
      e.pc = 3'(i % 6);
      sb_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 80 && !bus.done; i++) tick();
    check(tag, int'(bus.done), 1);
  endtask

  // 1-cycle-latency memory models; junk when not enabled so a mistimed capture shows.
  always @(posedge clk) begin
    bus.mem_data  <= bus.mem_en  ? rom[bus.mem_addr]  : 13'h1fff;
    bus1.mem_data <= bus1.mem_en ? rom[bus1.mem_addr] : 13'h1fff;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: a transfer happens at the next rising edge when valid and ready
  // are both high mid-cycle.
  always @(negedge clk) begin
    if (bus1.mem_en) mem_en1_cnt <= mem_en1_cnt + 1;
    if (bus.done) saw_done <= 1'b1;
    if (mon_en && bus.instr_valid && bus.instr_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_xfer", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_a",  int'(bus.a_in),    int'(e.a));
        check("sb_b",  int'(bus.b_in),    int'(e.b));
        check("sb_c",  int'(bus.c_in),    int'(e.c));
        check("sb_op", int'(bus.op_code), int'(e.op));
        check("sb_pc", int'(bus.pc),      int'(e.pc));
        check("sb_no_fetch_ahead", int'(bus.mem_en), 0);
      end
      if (chk_tput && prev_xfer >= 0) check("throughput", cyc + 1 - prev_xfer, 3);
      prev_xfer = cyc + 1;
      last_xfer = cyc + 1;
      n_xfer    = n_xfer + 1;
    end
  end

  initial begin
    for (int i = 0; i < 8; i++)
      rom[i] = {4'(prog_a[i]), 4'(prog_b[i]), 1'(prog_c[i]), 4'(prog_op[i])};
    bus.start = 1'b0;
    bus.instr_ready = 1'b1;
    bus1.start = 1'b0;
    bus1.instr_ready = 1'b1;

    // Reset values
    repeat (3) tick();
    check("rst_mem_en",   int'(bus.mem_en), 0);
    check("rst_mem_addr", int'(bus.mem_addr), 0);
    check("rst_valid",    int'(bus.instr_valid), 0);
    check("rst_fields",   int'({bus.a_in, bus.b_in, bus.c_in, bus.op_code}), 0);
    check("rst_pc",       int'(bus.pc), 0);
    check("rst_busy",     int'(bus.busy), 0);
    check("rst_done",     int'(bus.done), 0);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

`ifdef FETCH_LOOP_EN
    // Two full passes without stopping.
    push_prog(0, 12);
    chk_tput = 1'b1;
    pulse_start();
    for (int i = 0; i < 60 && n_xfer < 6; i++) tick();
    check("loop_wrap_mem_en", int'(bus.mem_en), 1);
    check("loop_wrap_addr",   int'(bus.mem_addr), 0);
    check("loop_wrap_pc",     int'(bus.pc), 0);
    for (int i = 0; i < 60 && n_xfer < 12; i++) tick();
    check("loop_xfers", n_xfer, 12);
    tick();
    check("loop_done_low", int'(saw_done), 0);
    check("loop_busy",     int'(bus.busy), 1);
    check("loop_sb_drained", sb_q.size(), 0);
`else
    // Run-through with a busy-time start pulse and latency checks.
    push_prog(0, 6);
    chk_tput = 1'b1;
    pulse_start();                                   // edge E0
    check("lat_mem_en_e0",   int'(bus.mem_en), 1);
    check("lat_mem_addr_e0", int'(bus.mem_addr), 0);
    check("lat_busy_e0",     int'(bus.busy), 1);
    bus.start = 1'b1;                                // ignored while busy
    tick();                                          // E0+1
    bus.start = 1'b0;
    check("lat_mem_en_e1", int'(bus.mem_en), 0);
    check("lat_valid_e1",  int'(bus.instr_valid), 0);
    tick();                                          // E0+2, accepted at E0+3
    check("lat_valid_e2",  int'(bus.instr_valid), 1);
    wait_done("run_done");
    check("done_edge", cyc, last_xfer);
    check("run_busy_after", int'(bus.busy), 0);
    check("run_sb_drained", sb_q.size(), 0);
    chk_tput = 1'b0;

    // Restart from DONE with backpressure at pc=2.
    push_prog(0, 6);
    pulse_start();
    check("restart_mem_en",   int'(bus.mem_en), 1);
    check("restart_mem_addr", int'(bus.mem_addr), 0);
    check("restart_pc",       int'(bus.pc), 0);
    check("restart_done",     int'(bus.done), 0);
    for (int i = 0; i < 40 && !(bus.instr_valid && bus.pc == 3'd2); i++) tick();
    check("bp_reached_pc2", int'(bus.instr_valid && bus.pc == 3'd2), 1);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid",  int'(bus.instr_valid), 1);
      check("bp_fields", int'({bus.a_in, bus.b_in, bus.c_in, bus.op_code}),
            int'({4'd4, 4'd3, 1'b0, 4'd1}));
      check("bp_mem_en", int'(bus.mem_en), 0);
      check("bp_pc",     int'(bus.pc), 2);
    end
    bus.instr_ready = 1'b1;
    tick();
    check("bp_next_mem_en",   int'(bus.mem_en), 1);
    check("bp_next_mem_addr", int'(bus.mem_addr), 3);
    wait_done("bp_done");
    check("bp_sb_drained", sb_q.size(), 0);

    // Reset while holding the pc=4 instruction.
    push_prog(0, 4);
    pulse_start();
    for (int i = 0; i < 40 && !(bus.instr_valid && bus.pc == 3'd4); i++) tick();
    check("rh_reached_pc4", int'(bus.instr_valid && bus.pc == 3'd4), 1);
    bus.instr_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rh_valid",  int'(bus.instr_valid), 0);
    check("rh_pc",     int'(bus.pc), 0);
    check("rh_fields", int'({bus.a_in, bus.b_in, bus.c_in, bus.op_code}), 0);
    check("rh_busy",   int'(bus.busy), 0);
    check("rh_mem_en", int'(bus.mem_en), 0);
    check("rh_sb_drained", sb_q.size(), 0);
    tick();
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    tick();
    check("rh_idle_busy",   int'(bus.busy), 0);
    check("rh_idle_done",   int'(bus.done), 0);
    check("rh_idle_mem_en", int'(bus.mem_en), 0);

    // Single-entry program on the PROG_LEN=1 instance.
    mem_en1_cnt = 0;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int i = 0; i < 20 && !bus1.instr_valid; i++) tick();
    check("p1_valid",  int'(bus1.instr_valid), 1);
    check("p1_fields", int'({bus1.a_in, bus1.b_in, bus1.c_in, bus1.op_code}),
          int'({4'd2, 4'd8, 1'b1, 4'd0}));
    check("p1_pc",     int'(bus1.pc), 0);
    tick();
    check("p1_done",   int'(bus1.done), 1);
    check("p1_busy",   int'(bus1.busy), 0);
    repeat (4) tick();
    check("p1_fetches", mem_en1_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
